// File: rtl/kvs_req_sched.sv
// In-order command scheduler in front of the hash-map KV store: input FIFO, insert fence,
// lookup/modify sequencing and a credit-protected response FIFO.
// Define KVS_SCHED_STATS_EN to add the stat_hits/stat_misses/stat_stalls counters.
module kvs_req_sched #(
    parameter int unsigned KEY_BITS   = 32,
    parameter int unsigned VAL_BITS   = 32,
    parameter int unsigned CMD_DEPTH  = 8,
    parameter int unsigned RESP_DEPTH = 8,
    parameter int unsigned LOOKUP_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [1:0]          s_op,
    input  logic [KEY_BITS-1:0] s_key,
    input  logic [VAL_BITS-1:0] s_value,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [1:0]          m_op,
    output logic                m_hit,
    output logic [VAL_BITS-1:0] m_value,
    output logic                kvs_insert,
    input  logic                kvs_busy,
    output logic [KEY_BITS-1:0] kvs_ins_key,
    output logic [VAL_BITS-1:0] kvs_ins_value,
    output logic                kvs_lookup,
    output logic [KEY_BITS-1:0] kvs_key,
    output logic                kvs_modify,
    output logic                kvs_del,
    output logic [VAL_BITS-1:0] kvs_mod_value,
    input  logic                kvs_valid,
    input  logic [VAL_BITS-1:0] kvs_res
`ifdef KVS_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_stalls
`endif
);
    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RESP_DEPTH);
    localparam logic [RAW:0] CredInit = (RAW+1)'(RESP_DEPTH);
    localparam logic [1:0] OpLookup = 2'd0;
    localparam logic [1:0] OpInsert = 2'd1;
    localparam logic [1:0] OpDelete = 2'd3;

    typedef enum logic [1:0] {StRun, StMod, StFence0, StFence} state_e;
    state_e state_q, state_d;

    logic [1:0]          cmd_op_mem  [CMD_DEPTH];
    logic [KEY_BITS-1:0] cmd_key_mem [CMD_DEPTH];
    logic [VAL_BITS-1:0] cmd_val_mem [CMD_DEPTH];
    logic [CAW:0]        cmd_wr_q, cmd_rd_q;
    logic                cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [1:0]          head_op;
    logic [KEY_BITS-1:0] head_key;
    logic [VAL_BITS-1:0] head_val;

    logic [1:0]          resp_op_mem  [RESP_DEPTH];
    logic                resp_hit_mem [RESP_DEPTH];
    logic [VAL_BITS-1:0] resp_val_mem [RESP_DEPTH];
    logic [RAW:0]        resp_wr_q, resp_rd_q;
    logic                resp_full, resp_empty, resp_push, resp_pop;

    logic [RAW:0]        cred_q, cred_d;
    logic [1:0]          mod_op_q, mod_op_d;
    logic [VAL_BITS-1:0] mod_val_q, mod_val_d;
    logic                issue_resp;
    logic                track_v_q  [LOOKUP_LAT];
    logic [1:0]          track_op_q [LOOKUP_LAT];
    logic                tail_v;

    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                       (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
    assign s_ready   = !cmd_full;
    assign cmd_push  = s_valid && !cmd_full;
    assign head_op   = cmd_op_mem[cmd_rd_q[CAW-1:0]];
    assign head_key  = cmd_key_mem[cmd_rd_q[CAW-1:0]];
    assign head_val  = cmd_val_mem[cmd_rd_q[CAW-1:0]];

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_op_mem[cmd_wr_q[CAW-1:0]]  <= s_op;
            cmd_key_mem[cmd_wr_q[CAW-1:0]] <= s_key;
            cmd_val_mem[cmd_wr_q[CAW-1:0]] <= s_value;
        end
        if (resp_push) begin
            resp_op_mem[resp_wr_q[RAW-1:0]]  <= track_op_q[LOOKUP_LAT-1];
            resp_hit_mem[resp_wr_q[RAW-1:0]] <= kvs_valid;
            resp_val_mem[resp_wr_q[RAW-1:0]] <= kvs_valid ? kvs_res : '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        mod_op_d      = mod_op_q;
        mod_val_d     = mod_val_q;
        cmd_pop       = 1'b0;
        issue_resp    = 1'b0;
        kvs_insert    = 1'b0;
        kvs_ins_key   = '0;
        kvs_ins_value = '0;
        kvs_lookup    = 1'b0;
        kvs_key       = '0;
        kvs_modify    = 1'b0;
        kvs_del       = 1'b0;
        kvs_mod_value = '0;
        case (state_q)
            StRun: begin
                if (!cmd_empty) begin
                    if (head_op == OpInsert) begin
                        if (!kvs_busy) begin
                            kvs_insert    = 1'b1;
                            kvs_ins_key   = head_key;
                            kvs_ins_value = head_val;
                            cmd_pop       = 1'b1;
                            state_d       = StFence0;
                        end
                    end else if (cred_q != '0) begin
                        kvs_lookup = 1'b1;
                        kvs_key    = head_key;
                        cmd_pop    = 1'b1;
                        issue_resp = 1'b1;
                        if (head_op != OpLookup) begin
                            mod_op_d  = head_op;
                            mod_val_d = head_val;
                            state_d   = StMod;
                        end
                    end
                end
            end
            StMod: begin
                kvs_modify    = 1'b1;
                kvs_del       = (mod_op_q == OpDelete);
                kvs_mod_value = mod_val_q;
                state_d       = StRun;
            end
            // The store may only raise busy the cycle after the insert, so skip one cycle first.
            StFence0: state_d = StFence;
            StFence: begin
                if (!kvs_busy) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign tail_v     = track_v_q[LOOKUP_LAT-1];
    assign resp_empty = (resp_wr_q == resp_rd_q);
    assign resp_full  = (resp_wr_q[RAW] != resp_rd_q[RAW]) &&
                        (resp_wr_q[RAW-1:0] == resp_rd_q[RAW-1:0]);
    assign resp_push  = tail_v && !resp_full;
    assign m_valid    = !resp_empty;
    assign resp_pop   = m_valid && m_ready;
    assign m_op       = m_valid ? resp_op_mem[resp_rd_q[RAW-1:0]] : 2'd0;
    assign m_hit      = m_valid ? resp_hit_mem[resp_rd_q[RAW-1:0]] : 1'b0;
    assign m_value    = m_valid ? resp_val_mem[resp_rd_q[RAW-1:0]] : '0;

    always_comb begin
        cred_d = cred_q;
        if (resp_pop && !issue_resp) begin
            cred_d = cred_q + 1'b1;
        end else if (!resp_pop && issue_resp) begin
            cred_d = cred_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            resp_wr_q <= '0;
            resp_rd_q <= '0;
            cred_q    <= CredInit;
            mod_op_q  <= '0;
            mod_val_q <= '0;
            for (int i = 0; i < int'(LOOKUP_LAT); i++) begin
                track_v_q[i]  <= 1'b0;
                track_op_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cred_q    <= cred_d;
            mod_op_q  <= mod_op_d;
            mod_val_q <= mod_val_d;
            if (cmd_push)  cmd_wr_q  <= cmd_wr_q + 1'b1;
            if (cmd_pop)   cmd_rd_q  <= cmd_rd_q + 1'b1;
            if (resp_push) resp_wr_q <= resp_wr_q + 1'b1;
            if (resp_pop)  resp_rd_q <= resp_rd_q + 1'b1;
            track_v_q[0]  <= issue_resp;
            track_op_q[0] <= issue_resp ? head_op : 2'd0;
            for (int i = 1; i < int'(LOOKUP_LAT); i++) begin
                track_v_q[i]  <= track_v_q[i-1];
                track_op_q[i] <= track_op_q[i-1];
            end
        end
    end

`ifdef KVS_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_stalls <= '0;
        end else begin
            if (tail_v && kvs_valid && stat_hits != '1)    stat_hits   <= stat_hits + 1'b1;
            if (tail_v && !kvs_valid && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            if (!cmd_empty && !cmd_pop && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_kvs_req_sched.sv
// Bench for kvs_req_sched: emulates the KV store and checks every response, strobe and
// issue against an in-order map model of the command semantics.
module tb_kvs_req_sched;
    localparam int unsigned LAT = 3;
    localparam int unsigned RD  = 8;
    localparam int unsigned CD  = 8;

    typedef struct {logic [1:0] op; logic [31:0] key; logic [31:0] val;} cmd_t;
    typedef struct {logic [1:0] op; logic hit; logic [31:0] val;} resp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        s_valid = 1'b0, s_ready;
    logic [1:0]  s_op = '0;
    logic [31:0] s_key = '0, s_value = '0;
    logic        m_valid, m_ready = 1'b0, m_hit;
    logic [1:0]  m_op;
    logic [31:0] m_value;
    logic        kvs_insert, kvs_busy = 1'b0, kvs_lookup, kvs_modify, kvs_del;
    logic [31:0] kvs_ins_key, kvs_ins_value, kvs_key, kvs_mod_value;
    logic        kvs_valid = 1'b0;
    logic [31:0] kvs_res = '0;

    kvs_req_sched #(.KEY_BITS(32), .VAL_BITS(32), .CMD_DEPTH(CD), .RESP_DEPTH(RD),
                    .LOOKUP_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_key(s_key), .s_value(s_value),
        .m_valid(m_valid), .m_ready(m_ready), .m_op(m_op), .m_hit(m_hit), .m_value(m_value),
        .kvs_insert(kvs_insert), .kvs_busy(kvs_busy), .kvs_ins_key(kvs_ins_key),
        .kvs_ins_value(kvs_ins_value), .kvs_lookup(kvs_lookup), .kvs_key(kvs_key),
        .kvs_modify(kvs_modify), .kvs_del(kvs_del), .kvs_mod_value(kvs_mod_value),
        .kvs_valid(kvs_valid), .kvs_res(kvs_res)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    cmd_t  src_q[$], iss_q[$];
    resp_t exp_q[$], log_q[$];
    logic [32:0] mod_log[$];
    int    lat_log[$], iss_cyc_q[$], lk_cyc_q[$];
    logic [31:0] store_map [logic [31:0]];
    logic [31:0] ref_map [logic [31:0]];
    bit          pv_q[$];
    logic [31:0] pd_q[$];
    int   busy_cnt = 0, busy_len = 0, mr_mode = 1, cyc = 0, ins_cyc = 0;
    int   outstanding = 0, n_lookups = 0, n_resp = 0;
    bit   gap_mode = 0, mod_pend = 0, prev_busy = 0, prev_ins = 0;
    bit   last_lk_v = 0, last_lk_hit = 0;
    logic [31:0] last_lk_key = '0;
    cmd_t mod_cmd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Store emulation and stimulus, driven just after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            kvs_busy = 0; kvs_valid = 0; kvs_res = '0; s_valid = 0; m_ready = 0;
        end else begin
            kvs_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (pv_q.size() >= LAT) begin
                kvs_valid = pv_q.pop_front();
                kvs_res   = pd_q.pop_front();
            end else begin
                kvs_valid = 0;
                kvs_res   = $urandom;
            end
            m_ready = (mr_mode == 0) ? 1'b0 : (mr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s_valid = (src_q.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
            s_op    = s_valid ? src_q[0].op : 2'd0;
            s_key   = s_valid ? src_q[0].key : '0;
            s_value = s_valid ? src_q[0].val : '0;
        end
    end

    // Compare process: samples mid-cycle, updates store and reference model.
    cmd_t  c;
    resp_t e, g;
    bit    idle_bad, lk_v, lk_hit, ex;
    logic [31:0] lk_dat, old;
    int    lat;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv_q.delete(); pd_q.delete(); iss_q.delete(); exp_q.delete(); iss_cyc_q.delete();
            store_map.delete(); ref_map.delete();
            busy_cnt = 0; mod_pend = 0; prev_busy = 0; prev_ins = 0; outstanding = 0;
            last_lk_v = 0;
        end else begin
            cyc++;
            idle_bad = (!kvs_lookup && kvs_key != '0) ||
                       (!kvs_insert && (kvs_ins_key != '0 || kvs_ins_value != '0)) ||
                       (!kvs_modify && (kvs_del || kvs_mod_value != '0)) ||
                       (!m_valid && (m_op != '0 || m_hit || m_value != '0));
            chk("idle_outputs_zero", 64'(idle_bad), 0);
            chk("modify_strobe", 64'(kvs_modify), 64'(mod_pend));
            if (mod_pend && kvs_modify) begin
                chk("modify_del", 64'(kvs_del), 64'(mod_cmd.op == 2'd3));
                chk("modify_value", 64'(kvs_mod_value), 64'(mod_cmd.val));
                mod_log.push_back({kvs_del, kvs_mod_value});
            end
            if (kvs_modify && last_lk_v && last_lk_hit) begin
                if (kvs_del) store_map.delete(last_lk_key);
                else store_map[last_lk_key] = kvs_mod_value;
            end
            mod_pend = 0;
            lk_v = 0; lk_hit = 0; lk_dat = $urandom;
            if (kvs_lookup || kvs_insert) begin
                chk("issue_exclusive", 64'(kvs_lookup && kvs_insert), 0);
                chk("fence_respected", 64'(prev_busy || prev_ins), 0);
                chk("issue_has_command", 64'(iss_q.size() > 0), 1);
                if (iss_q.size() > 0) begin
                    c = iss_q.pop_front();
                    chk("issue_kind", 64'(kvs_insert), 64'(c.op == 2'd1));
                    if (kvs_insert) begin
                        chk("insert_key", 64'(kvs_ins_key), 64'(c.key));
                        chk("insert_value", 64'(kvs_ins_value), 64'(c.val));
                        store_map[kvs_ins_key] = kvs_ins_value;
                        busy_cnt = (busy_len >= 0) ? busy_len : int'($urandom_range(0, 3));
                        ins_cyc = cyc;
                    end else begin
                        chk("lookup_key", 64'(kvs_key), 64'(c.key));
                        lk_v = 1;
                        lk_hit = store_map.exists(kvs_key);
                        if (lk_hit) lk_dat = store_map[kvs_key];
                        n_lookups++;
                        lk_cyc_q.push_back(cyc);
                        iss_cyc_q.push_back(cyc);
                        outstanding++;
                        chk("credit_bound", 64'(outstanding <= int'(RD)), 1);
                        if (c.op >= 2'd2) begin mod_pend = 1; mod_cmd = c; end
                    end
                end
            end
            pv_q.push_back(lk_v && lk_hit);
            pd_q.push_back(lk_dat);
            last_lk_v = lk_v; last_lk_hit = lk_hit; last_lk_key = kvs_key;
            if (m_valid && m_ready) begin
                n_resp++;
                outstanding--;
                chk("response_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    g.op = m_op; g.hit = m_hit; g.val = m_value;
                    chk("resp_op", 64'(g.op), 64'(e.op));
                    chk("resp_hit", 64'(g.hit), 64'(e.hit));
                    chk("resp_value", 64'(g.val), 64'(e.val));
                    log_q.push_back(g);
                end
                if (iss_cyc_q.size() > 0) begin
                    lat = cyc - iss_cyc_q.pop_front();
                    lat_log.push_back(lat);
                    chk("resp_latency_min", 64'(lat >= int'(LAT) + 1), 1);
                end
            end
            if (s_valid && s_ready && src_q.size() > 0) begin
                c = src_q.pop_front();
                ex = ref_map.exists(c.key);
                old = ex ? ref_map[c.key] : 32'h0;
                e.op = c.op; e.hit = ex; e.val = old;
                case (c.op)
                    2'd1: ref_map[c.key] = c.val;
                    2'd2: begin exp_q.push_back(e); if (ex) ref_map[c.key] = c.val; end
                    2'd3: begin exp_q.push_back(e); if (ex) ref_map.delete(c.key); end
                    default: exp_q.push_back(e);
                endcase
                iss_q.push_back(c);
            end
            prev_busy = kvs_busy;
            prev_ins  = kvs_insert;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
        cmd_t x;
        x.op = op; x.key = key; x.val = val;
        src_q.push_back(x);
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (src_q.size() == 0 && iss_q.size() == 0 && exp_q.size() == 0 && !mod_pend);
        end
        chk("drain_within_budget", 64'(done), 1);
    endtask

    task automatic check_resp(input int idx, input logic [1:0] op, input logic hit,
                              input logic [31:0] val);
        chk("resp_log_len", 64'(log_q.size() > idx), 1);
        if (log_q.size() > idx) begin
            chk("pinned_op", 64'(log_q[idx].op), 64'(op));
            chk("pinned_hit", 64'(log_q[idx].hit), 64'(hit));
            chk("pinned_value", 64'(log_q[idx].val), 64'(val));
        end
    endtask

    task automatic check_reset_state();
        chk("reset_s_ready", 64'(s_ready), 1);
        chk("reset_m_valid", 64'(m_valid), 0);
        chk("reset_strobes", 64'({kvs_lookup, kvs_insert, kvs_modify, kvs_del}), 0);
        chk("reset_values", 64'(kvs_key | kvs_ins_key | kvs_ins_value | kvs_mod_value | m_value), 0);
    endtask

    int n0, r0, b0;
    initial begin
        repeat (3) tick();
        check_reset_state();
        rst_n = 1;

        // Insert with busy held for 3 cycles, then lookup of the same key.
        busy_len = 3; mr_mode = 1;
        lk_cyc_q.delete();
        send(2'd1, 32'd5, 32'hAA);
        send(2'd0, 32'd5, 32'h0);
        drain(200);
        chk("lookup_count_after_insert", 64'(lk_cyc_q.size()), 1);
        if (lk_cyc_q.size() > 0) chk("insert_to_lookup_gap", 64'(lk_cyc_q[0] - ins_cyc), 5);
        check_resp(0, 2'd0, 1'b1, 32'hAA);
        if (lat_log.size() > 0) chk("first_resp_latency", 64'(lat_log[0]), 64'(LAT + 1));

        // Update, lookup, delete, lookup.
        send(2'd2, 32'd5, 32'hBB);
        send(2'd0, 32'd5, 32'h0);
        send(2'd3, 32'd5, 32'h0);
        send(2'd0, 32'd5, 32'h0);
        drain(200);
        check_resp(1, 2'd2, 1'b1, 32'hAA);
        check_resp(2, 2'd0, 1'b1, 32'hBB);
        check_resp(3, 2'd3, 1'b1, 32'hBB);
        check_resp(4, 2'd0, 1'b0, 32'h0);
        chk("mod_log_len", 64'(mod_log.size()), 2);
        if (mod_log.size() >= 2) begin
            chk("update_mod_strobe", 64'(mod_log[0]), 64'({1'b0, 32'hBB}));
            chk("delete_mod_del", 64'(mod_log[1][32]), 1);
        end

        // Backpressure: only RESP_DEPTH lookups may issue.
        mr_mode = 0;
        n0 = n_lookups; r0 = log_q.size();
        for (int i = 0; i < 20; i++) send(2'd0, 32'(i), 32'h0);
        repeat (40) tick();
        chk("bp_issued", 64'(n_lookups - n0), 64'(RD));
        chk("bp_s_ready", 64'(s_ready), 0);
        chk("bp_m_valid", 64'(m_valid), 1);
        chk("bp_unaccepted", 64'(src_q.size()), 64'(20 - RD - CD));
        mr_mode = 1;
        drain(400);
        chk("bp_drained", 64'(log_q.size() - r0), 20);

        // Back-to-back lookups: one issue per cycle.
        busy_len = 1;
        for (int i = 0; i < 4; i++) send(2'd1, 32'(i), 32'h100 + 32'(i));
        drain(200);
        lk_cyc_q.delete();
        for (int i = 0; i < 16; i++) send(2'd0, 32'(i % 8), 32'h0);
        drain(400);
        chk("b2b_count", 64'(lk_cyc_q.size()), 16);
        if (lk_cyc_q.size() == 16) chk("b2b_span", 64'(lk_cyc_q[15] - lk_cyc_q[0]), 15);

        // Reset mid-stream must leave no stale responses.
        for (int i = 0; i < 16; i++) send(2'd0, 32'(i % 4), 32'h0);
        repeat (6) tick();
        rst_n = 0;
        src_q.delete();
        tick();
        check_reset_state();
        rst_n = 1;
        b0 = n_resp;
        repeat (20) tick();
        chk("no_stale_responses", 64'(n_resp - b0), 0);

        // Randomized traffic.
        busy_len = -1; mr_mode = 2; gap_mode = 1;
        for (int i = 0; i < 400; i++)
            send(2'($urandom_range(0, 3)), 32'($urandom_range(0, 7)), $urandom);
        drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/kvs_req_sched.md
# kvs_req_sched

Command scheduler that sits directly upstream of the hash-map key-value store (`kvs`). It accepts a single in-order stream of lookup/insert/update/delete commands and buffers them in an input FIFO. It drives the store's insert port and its lookup/modify port, respecting the insert `busy` handshake and the next-cycle modify rule. Store results return through a credit-protected response FIFO with backpressure.

## Interface
Parameters:
- `KEY_BITS`, 32, key width.
- `VAL_BITS`, 32, value width.
- `CMD_DEPTH`, 8, input FIFO entries; power of 2, ≥2.
- `RESP_DEPTH`, 8, response FIFO entries; power of 2, ≥2.
- `LOOKUP_LAT`, 3, cycles from `kvs_lookup` to `kvs_valid`; ≥1.

Ports:
- Clocking and reset:
  - `clk` in 1: single clock.
  - `rst_n` in 1: asynchronous, active-low reset.
- Command stream:
  - `s_valid` in 1, `s_ready` out 1: command handshake.
  - `s_op` in 2: 0=LOOKUP, 1=INSERT, 2=UPDATE, 3=DELETE.
  - `s_key` in KEY_BITS: command key.
  - `s_value` in VAL_BITS: used by INSERT and UPDATE.
- Response stream:
  - `m_valid` in/out: `m_valid` out 1, `m_ready` in 1: response handshake.
  - `m_op` out 2: op of the originating command.
  - `m_hit` out 1: key was present.
  - `m_value` out VAL_BITS: value read at lookup time; 0 on miss.
- Store insert port:
  - `kvs_insert` out 1, `kvs_busy` in 1.
  - `kvs_ins_key` out KEY_BITS, `kvs_ins_value` out VAL_BITS.
- Store lookup/modify port:
  - `kvs_lookup` out 1, `kvs_key` out KEY_BITS.
  - `kvs_modify` out 1, `kvs_del` out 1, `kvs_mod_value` out VAL_BITS.
  - `kvs_valid` in 1, `kvs_res` in VAL_BITS.

## Operation
- Input FIFO: `s_ready` = not full; push on `s_valid && s_ready`.
- Commands issue strictly in order from the FIFO head. INSERT produces no response; every other op produces exactly one response.
- Credit counter `cred` (reset RESP_DEPTH):
  - Decrement on each LOOKUP/UPDATE/DELETE issue.
  - Increment on each response pop (`m_valid && m_ready`).
  - Issue is allowed only when `cred > 0`, so responses never overflow.
- FSM states:
  - RUN:
    - Head LOOKUP with credit: pulse `kvs_lookup` and `kvs_key`; pop; stay in RUN.
    - Head UPDATE/DELETE with credit: pulse `kvs_lookup`; latch value and op; pop; go to MOD.
    - Head INSERT: if `!kvs_busy`, pulse `kvs_insert` with key and value; pop; go to FENCE. Otherwise hold.
  - MOD (one cycle):
    - Drive `kvs_modify=1`, `kvs_del = (op==DELETE)`, `kvs_mod_value` = latched value.
    - No issue this cycle; return to RUN.
  - FENCE:
    - No issue. Wait one cycle, then until `kvs_busy` is sampled 0; return to RUN.
    - This guarantees an insert is visible to all subsequent commands.
- Op tracking: a LOOKUP_LAT-deep shift register of `{valid, op}` accompanies each lookup. At `kvs_valid` (coincident with the shift-register tail), push `{op, hit=1, kvs_res}`.
- Miss handling: if the tail is valid and `kvs_valid=0`, push `{op, hit=0, value=0}`.
- Modify on a miss is harmless; the store ignores it.
- Idle outputs: `kvs_*_key` and value outputs are 0 when not strobed.

## Timing
- Reset: all outputs 0, except `s_ready` = 1 and `cred` = RESP_DEPTH. FIFOs are emptied and the FSM enters RUN.
- Reset mid-operation drops queued and in-flight commands. No response is produced for them.
- Min latency from `s_valid` to issue: 1 cycle, through the FIFO.
- Response appears on `m_valid` one cycle after the tail, i.e. issue + LOOKUP_LAT + 1.
- Throughput: LOOKUP 1 per cycle; UPDATE/DELETE 1 per 2 cycles; INSERT limited by `kvs_busy` plus the fence.
- Simultaneous push/pop on either FIFO when full or empty follows the normal rule: a full FIFO refuses the push even if a pop occurs that cycle.
- Counter wrap-around: FIFO pointers are log2(depth)+1 bits wide, and wrap is natural.

## Configuration
- `KVS_SCHED_STATS_EN` defined: adds output ports `stat_hits`, `stat_misses`, and `stat_stalls` (32 bits, saturating at 2^32−1, reset 0).
  - `stat_stalls` counts cycles where the head is valid but not issued.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Insert then lookup: INSERT key=5, value=0xAA. Model holds busy for 3 cycles; LOOKUP 5 follows. Expect the lookup issued only after busy falls, then response `{LOOKUP, hit=1, 0xAA}`.
- Update: UPDATE key=5, value=0xBB. Expect `kvs_modify=1`, `kvs_mod_value=0xBB` on the cycle after `kvs_lookup`; response value 0xAA. A following LOOKUP 5 returns 0xBB.
- Delete and miss: DELETE 5 drives `kvs_del=1` with `kvs_modify`. A subsequent LOOKUP 5 yields `hit=0`, value=0.
- Backpressure: hold `m_ready=0` and send 20 LOOKUPs. Exactly RESP_DEPTH=8 issue; `s_ready` falls after the input FIFO fills. Releasing `m_ready` drains all 20 in order.
- Back-to-back: 16 LOOKUPs give one `kvs_lookup` per cycle with responses in order. Reset asserted mid-stream clears everything, and no stale responses appear afterwards.
